// File: rtl/menu_controller.sv
// -----------------------------------------------------------------------------
// menu_controller
//
// Screen/selection controller for the game front-end menu. The keyboard
// decoder supplies level-sensitive key inputs. Each key acts on its rising
// edge only. A held single up or down key also auto-repeats once every
// REPEAT_DELAY cycles. All outputs are registered, so a key edge or a
// game_over pulse shows up on the clock edge that samples it.
//
// Screens (menu_state):
//   0 Main, 1 StartGame, 2 Control, 3 About, 4 Exit (5..7 illegal -> Main)
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous, active-low reset
//   key_up       level, up key held
//   key_down     level, down key held
//   key_enter    level, enter key held
//   key_esc      level, escape key held
//   game_over    one-cycle pulse from game logic at end of a race
//   menu_state   current screen (also the FSM state, exposed for debug)
//   menu_counter highlighted item within the current screen
//   game_start   one-cycle pulse, high during the first cycle in StartGame
//   quit         one-cycle pulse when exit is confirmed
// -----------------------------------------------------------------------------
module menu_controller #(
  parameter int REPEAT_DELAY = 32_500_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_up,
  input  logic       key_down,
  input  logic       key_enter,
  input  logic       key_esc,
  input  logic       game_over,
  output logic [2:0] menu_state,
  output logic [1:0] menu_counter,
  output logic       game_start,
  output logic       quit
);

  localparam logic [2:0] ST_MAIN    = 3'd0;
  localparam logic [2:0] ST_START   = 3'd1;
  localparam logic [2:0] ST_CONTROL = 3'd2;
  localparam logic [2:0] ST_ABOUT   = 3'd3;
  localparam logic [2:0] ST_EXIT    = 3'd4;

  // The repeat counter runs 0 .. REPEAT_DELAY-1 and then fires.
  localparam int            RW       = (REPEAT_DELAY > 1) ? $clog2(REPEAT_DELAY) : 1;
  localparam logic [RW-1:0] RPT_LAST = RW'(REPEAT_DELAY - 1);

  // ---------------------------------------------------------------------------
  // Edge detection. The previous-value flops reset to 0, so a key held through
  // reset release produces an edge on the first clock after release.
  // ---------------------------------------------------------------------------
  logic up_q;
  logic down_q;
  logic enter_q;
  logic esc_q;

  logic up_edge;
  logic down_edge;
  logic enter_edge;
  logic esc_edge;

  assign up_edge    = key_up    & ~up_q;
  assign down_edge  = key_down  & ~down_q;
  assign enter_edge = key_enter & ~enter_q;
  assign esc_edge   = key_esc   & ~esc_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      up_q    <= 1'b0;
      down_q  <= 1'b0;
      enter_q <= 1'b0;
      esc_q   <= 1'b0;
    end else begin
      up_q    <= key_up;
      down_q  <= key_down;
      enter_q <= key_enter;
      esc_q   <= key_esc;
    end
  end

  // ---------------------------------------------------------------------------
  // Auto-repeat. Exactly one of up/down must be high and already high last
  // cycle. Requiring the previous value keeps the edge cycle out of the count,
  // so the first repeat lands REPEAT_DELAY cycles after the edge.
  // ---------------------------------------------------------------------------
  logic [RW-1:0] rpt_cnt;
  logic          single_held;
  logic          rpt_fire;

  assign single_held = (key_up   & up_q   & ~key_down) |
                       (key_down & down_q & ~key_up);
  assign rpt_fire    = single_held & (rpt_cnt == RPT_LAST);

  // Net up/down steps for this cycle. Simultaneous up and down edges cancel.
  // rpt_fire already implies that only one key is high.
  logic step_up;
  logic step_down;

  assign step_up   = (up_edge   & ~down_edge) | (rpt_fire & key_up);
  assign step_down = (down_edge & ~up_edge)   | (rpt_fire & key_down);

  // ---------------------------------------------------------------------------
  // Next-state logic. Priority inside each screen is esc > enter > up/down.
  // A lower-priority event in the same cycle is dropped.
  // ---------------------------------------------------------------------------
  logic [2:0] nxt_state;
  logic [1:0] nxt_counter;
  logic       nxt_game_start;
  logic       nxt_quit;

  always_comb begin
    nxt_state      = menu_state;
    nxt_counter    = menu_counter;
    nxt_game_start = 1'b0;
    nxt_quit       = 1'b0;

    case (menu_state)
      ST_MAIN: begin
        if (esc_edge) begin
          // Esc does nothing in Main, but it still swallows lower-priority keys.
          nxt_state   = menu_state;
        end else if (enter_edge) begin
          // Items 0..3 map onto screens 1..4.
          nxt_state = {1'b0, menu_counter} + 3'd1;
          if (menu_counter == 2'd3) begin
            nxt_counter = 2'd1;           // Exit opens with "No" highlighted
          end else begin
            nxt_counter = 2'd0;
          end
          nxt_game_start = (menu_counter == 2'd0);
        end else if (step_up) begin
          nxt_counter = menu_counter - 2'd1;   // wraps 0 -> 3
        end else if (step_down) begin
          nxt_counter = menu_counter + 2'd1;   // wraps 3 -> 0
        end
      end

      ST_START: begin
        if (esc_edge || game_over) begin
          nxt_state   = ST_MAIN;
          nxt_counter = 2'd0;
        end
      end

      ST_CONTROL: begin
        if (esc_edge || enter_edge) begin
          nxt_state   = ST_MAIN;
          nxt_counter = 2'd1;
        end
      end

      ST_ABOUT: begin
        if (esc_edge || enter_edge) begin
          nxt_state   = ST_MAIN;
          nxt_counter = 2'd2;
        end
      end

      ST_EXIT: begin
        if (esc_edge) begin
          nxt_state   = ST_MAIN;
          nxt_counter = 2'd3;
        end else if (enter_edge) begin
          nxt_state = ST_MAIN;
          if (menu_counter == 2'd0) begin
            // "Yes" confirmed
            nxt_quit    = 1'b1;
            nxt_counter = 2'd0;
          end else begin
            nxt_counter = 2'd3;
          end
        end else if (step_up || step_down) begin
          // Only two choices, so up and down both toggle.
          nxt_counter = {1'b0, ~menu_counter[0]};
        end
      end

      default: begin
        // Illegal encodings 5..7 recover to Main.
        nxt_state   = ST_MAIN;
        nxt_counter = 2'd0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State, output and repeat-counter registers.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      menu_state   <= ST_MAIN;
      menu_counter <= 2'd0;
      game_start   <= 1'b0;
      quit         <= 1'b0;
    end else begin
      menu_state   <= nxt_state;
      menu_counter <= nxt_counter;
      game_start   <= nxt_game_start;
      quit         <= nxt_quit;
    end
  end

  // The repeat counter restarts when the key is released, when both keys are
  // high, when the screen changes, and after each repeat step.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rpt_cnt <= '0;
    end else if (!single_held || rpt_fire || (nxt_state != menu_state)) begin
      rpt_cnt <= '0;
    end else begin
      rpt_cnt <= rpt_cnt + RW'(1);
    end
  end

endmodule

// File: tb/tb_menu_controller.sv
// -----------------------------------------------------------------------------
// tb_menu_controller
//
// Directed bench for menu_controller with REPEAT_DELAY = 4. A behavioural menu
// model runs next to the DUT and is compared on every falling clock edge.
// Hand-computed screen/counter values at key points also pin the model.
// -----------------------------------------------------------------------------
module tb_menu_controller;

  localparam int D = 4;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic       key_up    = 1'b0;
  logic       key_down  = 1'b0;
  logic       key_enter = 1'b0;
  logic       key_esc   = 1'b0;
  logic       game_over = 1'b0;
  logic [2:0] menu_state;
  logic [1:0] menu_counter;
  logic       game_start;
  logic       quit;

  menu_controller #(.REPEAT_DELAY(D)) dut (
    .clk          (clk),
    .rst          (rst),
    .key_up       (key_up),
    .key_down     (key_down),
    .key_enter    (key_enter),
    .key_esc      (key_esc),
    .game_over    (game_over),
    .menu_state   (menu_state),
    .menu_counter (menu_counter),
    .game_start   (game_start),
    .quit         (quit)
  );

  int checks   = 0;
  int errors   = 0;
  bit chk_en   = 1'b0;
  int gs_count = 0;
  int q_count  = 0;

  // ---------------------------------------------------------------------------
  // Behavioural model: screen number, item number, pulse flags, previous key
  // levels, and the age of the current single-key hold.
  // ---------------------------------------------------------------------------
  int m_state, m_cnt, age, dir, ns, nc;
  bit m_gs, m_quit;
  bit p_up, p_dn, p_en, p_esc;
  bit eu, ed, ee, es, single;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_state = 0; m_cnt = 0; m_gs = 0; m_quit = 0; age = 0;
      p_up = 0; p_dn = 0; p_en = 0; p_esc = 0;
    end else begin
      eu = key_up && !p_up;
      ed = key_down && !p_dn;
      ee = key_enter && !p_en;
      es = key_esc && !p_esc;
      ns = m_state; nc = m_cnt; m_gs = 0; m_quit = 0;
      dir = 0;
      if (eu && !ed) dir = -1;
      else if (ed && !eu) dir = 1;
      single = (key_up != key_down) && (key_up ? p_up : p_dn);
      if (single) age = age + 1;
      else age = 0;
      if (single && (age % D == 0)) dir = key_up ? -1 : 1;
      case (m_state)
        0: begin
          if (es) ;
          else if (ee) begin
            ns = m_cnt + 1;
            nc = (ns == 4) ? 1 : 0;
            m_gs = (ns == 1);
          end else if (dir != 0) nc = (m_cnt + dir + 4) % 4;
        end
        1: if (es || game_over) begin ns = 0; nc = 0; end
        2, 3: if (es || ee) begin ns = 0; nc = m_state - 1; end
        4: begin
          if (es) begin ns = 0; nc = 3; end
          else if (ee) begin
            ns = 0;
            if (m_cnt == 0) begin m_quit = 1; nc = 0; end
            else nc = 3;
          end else if (dir != 0) nc = 1 - m_cnt;
        end
        default: begin ns = 0; nc = 0; end
      endcase
      if (ns != m_state) age = 0;
      m_state = ns; m_cnt = nc;
      p_up = key_up; p_dn = key_down; p_en = key_enter; p_esc = key_esc;
    end
  end

  // ---------------------------------------------------------------------------
  // Scoreboard compare, every falling edge
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    if (chk_en) begin
      checks++;
      if (menu_state !== 3'(m_state) || menu_counter !== 2'(m_cnt) ||
          game_start !== m_gs || quit !== m_quit) begin
        errors++;
        $display("FAIL model_cmp t=%0t: got st=%0d cnt=%0d gs=%0b q=%0b, expected st=%0d cnt=%0d gs=%0b q=%0b",
                 $time, menu_state, menu_counter, game_start, quit,
                 m_state, m_cnt, m_gs, m_quit);
      end
      if (game_start === 1'b1) gs_count++;
      if (quit === 1'b1) q_count++;
    end
  end

  // ---------------------------------------------------------------------------
  // Driver and literal-check tasks (called on a falling edge)
  // ---------------------------------------------------------------------------
  task automatic chk(input string name, input int st, input int cnt);
    checks++;
    if (menu_state !== 3'(st) || menu_counter !== 2'(cnt)) begin
      errors++;
      $display("FAIL %s: got st=%0d cnt=%0d, expected st=%0d cnt=%0d",
               name, menu_state, menu_counter, st, cnt);
    end
  endtask

  task automatic chk_val(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  // One-cycle key press followed by one idle cycle.
  task automatic pulse(input bit u, input bit d, input bit en, input bit es_k);
    key_up = u; key_down = d; key_enter = en; key_esc = es_k;
    @(negedge clk);
    key_up = 0; key_down = 0; key_enter = 0; key_esc = 0;
    @(negedge clk);
  endtask

  task automatic go_over;
    game_over = 1;
    @(negedge clk);
    game_over = 0;
    @(negedge clk);
  endtask

  int gs0, q0;

  // ---------------------------------------------------------------------------
  // Directed stimulus
  // ---------------------------------------------------------------------------
  initial begin
    rst = 0;
    repeat (3) @(negedge clk);
    chk_en = 1;
    chk("reset", 0, 0);
    chk_val("reset_gs", int'(game_start), 0);
    chk_val("reset_quit", int'(quit), 0);
    rst = 1;
    @(negedge clk);

    // Main wrap-around
    pulse(0, 1, 0, 0); chk("down1", 0, 1);
    pulse(0, 1, 0, 0); chk("down2", 0, 2);
    pulse(0, 1, 0, 0); chk("down3", 0, 3);
    pulse(0, 1, 0, 0); chk("down_wrap", 0, 0);
    pulse(1, 0, 0, 0); chk("up_wrap", 0, 3);
    pulse(0, 1, 0, 0); chk("back_to0", 0, 0);

    // StartGame
    pulse(0, 0, 1, 0); chk("enter_start", 1, 0);
    chk_val("game_start_pulses", gs_count, 1);
    pulse(0, 1, 0, 0); chk("start_ignores_down", 1, 0);
    pulse(0, 0, 1, 0); chk("start_ignores_enter", 1, 0);
    chk_val("no_second_start", gs_count, 1);
    go_over(); chk("game_over_main", 0, 0);
    go_over(); chk("game_over_ignored_main", 0, 0);

    // Exit, confirm Yes
    pulse(0, 1, 0, 0); pulse(0, 1, 0, 0); pulse(0, 1, 0, 0);
    chk("to3", 0, 3);
    pulse(0, 0, 1, 0); chk("enter_exit", 4, 1);
    pulse(1, 0, 0, 0); chk("exit_up_yes", 4, 0);
    pulse(0, 0, 1, 0); chk("exit_quit", 0, 0);
    chk_val("quit_pulses", q_count, 1);

    // Control and back
    pulse(0, 1, 0, 0); pulse(0, 0, 1, 0); chk("enter_control", 2, 0);
    pulse(0, 1, 0, 0); chk("control_ignores_down", 2, 0);
    pulse(0, 0, 0, 1); chk("control_esc", 0, 1);

    // About, enter+esc together; then up+down together in Main
    pulse(0, 1, 0, 0); pulse(0, 0, 1, 0); chk("enter_about", 3, 0);
    pulse(0, 0, 1, 1); chk("about_enter_esc", 0, 2);
    pulse(1, 1, 0, 0); chk("up_down_same", 0, 2);
    pulse(0, 0, 1, 1); chk("main_esc_blocks_enter", 0, 2);

    // Exit with No, and Exit via esc
    pulse(0, 1, 0, 0); pulse(0, 0, 1, 0); chk("exit_again", 4, 1);
    pulse(0, 0, 1, 0); chk("exit_no", 0, 3);
    pulse(0, 0, 1, 0); pulse(0, 0, 0, 1); chk("exit_esc", 0, 3);
    chk_val("no_extra_quit", q_count, 1);

    // Auto-repeat in Main: down held 13 cycles from 0
    pulse(0, 1, 0, 0); chk("rpt_start0", 0, 0);
    key_down = 1;
    for (int i = 1; i <= 13; i++) begin
      @(negedge clk);
      chk($sformatf("rpt_hold_%0d", i), 0, (1 + (i - 1) / D) % 4);
    end
    key_down = 0;
    repeat (6) @(negedge clk);
    chk("rpt_release", 0, 0);

    // Auto-repeat in Exit: up held 5 cycles toggles twice
    pulse(1, 0, 0, 0); pulse(0, 0, 1, 0); chk("rpt_exit_entry", 4, 1);
    key_up = 1;
    repeat (5) @(negedge clk);
    key_up = 0;
    chk("rpt_exit_toggle", 4, 1);
    repeat (6) @(negedge clk);
    chk("rpt_exit_release", 4, 1);
    pulse(0, 0, 0, 1); chk("rpt_exit_esc", 0, 3);

    // Key held through reset release gives an edge on the first clock
    key_down = 1;
    #2 rst = 0;
    @(negedge clk);
    chk("held_in_reset", 0, 0);
    rst = 1;
    @(negedge clk);
    key_down = 0;
    chk("held_through_reset", 0, 1);
    @(negedge clk);

    // Reset in Control while down is mid-repeat
    pulse(0, 0, 1, 0); chk("control_for_reset", 2, 0);
    gs0 = gs_count; q0 = q_count;
    key_down = 1;
    repeat (6) @(negedge clk);
    #2 rst = 0;
    #1;
    chk("async_reset", 0, 0);
    chk_val("async_reset_gs", int'(game_start), 0);
    chk_val("async_reset_quit", int'(quit), 0);
    @(negedge clk);
    key_down = 0;
    @(negedge clk);
    rst = 1;
    repeat (3) @(negedge clk);
    chk("after_reset", 0, 0);
    chk_val("reset_no_gs", gs_count, gs0);
    chk_val("reset_no_quit", q_count, q0);

    chk_en = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
